// File: rtl/param_proc.sv
// Multi-cycle 8-register processor: movi/mv finish in T1, ALU ops go through A/G in T1..T3.
// Optional zf/cf flag outputs are enabled by defining PARAM_PROC_FLAGS_EN.
module param_proc #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [8:0]        din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] R0,
  output logic [DATA_W-1:0] R1,
  output logic [DATA_W-1:0] R2,
  output logic [DATA_W-1:0] R3,
  output logic [DATA_W-1:0] R4,
  output logic [DATA_W-1:0] R5,
  output logic [DATA_W-1:0] R6,
  output logic [DATA_W-1:0] R7,
`ifdef PARAM_PROC_FLAGS_EN
  output logic              zf,
  output logic              cf,
`endif
  output logic [3:0]        tick
);

  localparam int SH_W = $clog2(DATA_W);

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MV   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_T1   = 4'b0010,
    S_T2   = 4'b0100,
    S_T3   = 4'b1000
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [8:0]        r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic [DATA_W-1:0] r_regs [8];

  logic [2:0]        w_op;
  logic [2:0]        w_rx;
  logic [2:0]        w_ry;
  logic [DATA_W-1:0] w_imm;
  logic [DATA_W-1:0] w_alu;
  logic              w_ld_a;
  logic              w_ld_g;
  logic              w_wr;

  assign w_op  = r_ir[8:6];
  assign w_rx  = r_ir[5:3];
  assign w_ry  = r_ir[2:0];
  assign w_imm = {{(DATA_W-3){r_ir[2]}}, r_ir[2:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    bus    = '0;
    done   = 1'b0;
    w_ld_a = 1'b0;
    w_ld_g = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_T1;
      end
      S_T1: begin
        if (w_op == OP_MOVI) begin
          bus    = w_imm;
          done   = 1'b1;
          w_wr   = 1'b1;
          w_next = S_IDLE;
        end else if (w_op == OP_MV) begin
          bus    = r_regs[w_ry];
          done   = 1'b1;
          w_wr   = 1'b1;
          w_next = S_IDLE;
        end else begin
          bus    = r_regs[w_rx];
          w_ld_a = 1'b1;
          w_next = S_T2;
        end
      end
      S_T2: begin
        bus    = (w_op == OP_ADDI) ? w_imm : r_regs[w_ry];
        w_ld_g = 1'b1;
        w_next = S_T3;
      end
      S_T3: begin
        bus    = r_g;
        done   = 1'b1;
        w_wr   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // ALU operates on A and the T2 bus value; only meaningful while w_ld_g is high
  always_comb begin
    w_alu = '0;
    case (w_op)
      OP_ADD, OP_ADDI: w_alu = r_a + bus;
      OP_SUB:          w_alu = r_a - bus;
      OP_AND:          w_alu = r_a & bus;
      OP_XOR:          w_alu = r_a ^ bus;
      OP_SLL:          w_alu = r_a << bus[SH_W-1:0];
      default:         w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir <= '0;
      r_a  <= '0;
      r_g  <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == S_IDLE && run) r_ir <= din;
      if (w_ld_a) r_a <= bus;
      if (w_ld_g) r_g <= w_alu;
      if (w_wr) r_regs[w_rx] <= bus;
    end
  end

`ifdef PARAM_PROC_FLAGS_EN
  logic w_cf;

  // carry of an unsigned add shows up as a wrapped (smaller) sum; borrow is A < operand
  always_comb begin
    w_cf = 1'b0;
    case (w_op)
      OP_ADD, OP_ADDI: w_cf = (w_alu < r_a);
      OP_SUB:          w_cf = (r_a < bus);
      default:         w_cf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      zf <= 1'b0;
      cf <= 1'b0;
    end else if (w_ld_g) begin
      zf <= (w_alu == '0);
      cf <= w_cf;
    end
  end
`endif

  assign busy = (r_state != S_IDLE);
  assign tick = r_state;
  assign R0   = r_regs[0];
  assign R1   = r_regs[1];
  assign R2   = r_regs[2];
  assign R3   = r_regs[3];
  assign R4   = r_regs[4];
  assign R5   = r_regs[5];
  assign R6   = r_regs[6];
  assign R7   = r_regs[7];

endmodule

// File: tb/tb_param_proc.sv
// Directed bench for param_proc: a 16-bit and an 8-bit instance run in lockstep on shared inputs.
module tb_param_proc;

  typedef struct {
    logic [8:0]  din;
    int          rx;
    logic [15:0] val;
    int          lat;
    bit          fchk;
    bit          zf;
    bit          cf;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        run;
  logic [8:0]  din;

  logic        busy16, done16, busy8, done8;
  logic [15:0] bus16;
  logic [7:0]  bus8;
  logic [3:0]  tick16, tick8;
  logic [15:0] r16 [8];
  logic [7:0]  r8 [8];
`ifdef PARAM_PROC_FLAGS_EN
  logic        zf16, cf16, zf8, cf8;
`endif

  logic [15:0] m16 [8];
  logic [7:0]  m8 [8];
  vec_t        t16 [17];
  vec_t        t8 [10];
  logic [3:0]  exp_tick [8];

  int n_chk  = 0;
  int n_pass = 0;

  param_proc #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .busy(busy16), .done(done16), .bus(bus16),
    .R0(r16[0]), .R1(r16[1]), .R2(r16[2]), .R3(r16[3]),
    .R4(r16[4]), .R5(r16[5]), .R6(r16[6]), .R7(r16[7]),
`ifdef PARAM_PROC_FLAGS_EN
    .zf(zf16), .cf(cf16),
`endif
    .tick(tick16)
  );

  param_proc #(.DATA_W(8)) dut8 (
    .clk(clk), .rst(rst), .run(run), .din(din),
    .busy(busy8), .done(done8), .bus(bus8),
    .R0(r8[0]), .R1(r8[1]), .R2(r8[2]), .R3(r8[3]),
    .R4(r8[4]), .R5(r8[5]), .R6(r8[6]), .R7(r8[7]),
`ifdef PARAM_PROC_FLAGS_EN
    .zf(zf8), .cf(cf8),
`endif
    .tick(tick8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Issue one instruction and wait (bounded) for done; returns to an IDLE negedge after the write edge.
  task automatic exec(input logic [8:0] d, output int lat);
    @(negedge clk);
    run = 1'b1;
    din = d;
    @(negedge clk);
    run = 1'b0;
    lat = 1;
    while (done16 !== 1'b1 && lat < 6) begin
      @(negedge clk);
      lat++;
    end
    chk("done_seen", {31'd0, done16}, 32'd1);
    @(negedge clk);
  endtask

  task automatic apply(input vec_t v, input bit is8, input int idx);
    int lat;
    exec(v.din, lat);
    chk($sformatf("lat[%0d%s]", idx, is8 ? "_w8" : ""), lat, v.lat);
    if (is8) begin
      m8[v.rx] = v.val[7:0];
      for (int r = 0; r < 8; r++)
        chk($sformatf("w8_v%0d_R%0d", idx, r), {24'd0, r8[r]}, {24'd0, m8[r]});
    end else begin
      m16[v.rx] = v.val;
      for (int r = 0; r < 8; r++)
        chk($sformatf("w16_v%0d_R%0d", idx, r), {16'd0, r16[r]}, {16'd0, m16[r]});
    end
`ifdef PARAM_PROC_FLAGS_EN
    if (v.fchk) begin
      chk($sformatf("zf_v%0d", idx), {31'd0, is8 ? zf8 : zf16}, {31'd0, v.zf});
      chk($sformatf("cf_v%0d", idx), {31'd0, is8 ? cf8 : cf16}, {31'd0, v.cf});
    end
`endif
  endtask

  initial begin
    t16 = '{
      '{9'b000_001_011, 1, 16'h0003, 1, 1'b0, 1'b0, 1'b0},
      '{9'b010_001_010, 1, 16'h0005, 3, 1'b0, 1'b0, 1'b0},
      '{9'b000_010_011, 2, 16'h0003, 1, 1'b0, 1'b0, 1'b0},
      '{9'b010_010_011, 2, 16'h0006, 3, 1'b0, 1'b0, 1'b0},
      '{9'b010_010_001, 2, 16'h0007, 3, 1'b0, 1'b0, 1'b0},
      '{9'b001_001_010, 1, 16'h000C, 3, 1'b1, 1'b0, 1'b0},
      '{9'b100_000_001, 0, 16'h000C, 1, 1'b0, 1'b0, 1'b0},
      '{9'b011_010_010, 2, 16'h0000, 3, 1'b1, 1'b1, 1'b0},
      '{9'b000_101_001, 5, 16'h0001, 1, 1'b0, 1'b0, 1'b0},
      '{9'b011_100_101, 4, 16'hFFFF, 3, 1'b1, 1'b0, 1'b1},
      '{9'b101_100_011, 4, 16'hFFFD, 3, 1'b1, 1'b0, 1'b0},
      '{9'b110_100_001, 4, 16'hFFF1, 3, 1'b0, 1'b0, 1'b0},
      '{9'b111_100_101, 4, 16'hFFE2, 3, 1'b1, 1'b0, 1'b0},
      '{9'b010_000_100, 0, 16'h0008, 3, 1'b1, 1'b0, 1'b1},
      '{9'b001_011_011, 3, 16'hFFFA, 3, 1'b1, 1'b0, 1'b1},
      '{9'b000_110_111, 6, 16'hFFFF, 1, 1'b0, 1'b0, 1'b0},
      '{9'b111_101_110, 5, 16'h8000, 3, 1'b0, 1'b0, 1'b0}
    };
    t8 = '{
      '{9'b000_010_001, 2, 16'h0001, 1, 1'b0, 1'b0, 1'b0},
      '{9'b000_110_001, 6, 16'h0001, 1, 1'b0, 1'b0, 1'b0},
      '{9'b000_111_011, 7, 16'h0003, 1, 1'b0, 1'b0, 1'b0},
      '{9'b001_111_111, 7, 16'h0006, 3, 1'b0, 1'b0, 1'b0},
      '{9'b010_111_001, 7, 16'h0007, 3, 1'b0, 1'b0, 1'b0},
      '{9'b111_110_111, 6, 16'h0080, 3, 1'b0, 1'b0, 1'b0},
      '{9'b010_110_001, 6, 16'h0081, 3, 1'b0, 1'b0, 1'b0},
      '{9'b000_111_001, 7, 16'h0001, 1, 1'b0, 1'b0, 1'b0},
      '{9'b111_110_111, 6, 16'h0002, 3, 1'b1, 1'b0, 1'b0},
      '{9'b010_110_111, 6, 16'h0001, 3, 1'b1, 1'b0, 1'b1}
    };
    exp_tick = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001};
    for (int r = 0; r < 8; r++) begin
      m16[r] = '0;
      m8[r]  = '0;
    end

    // reset state, then run already high at release (movi R3,-3)
    rst = 1'b0;
    run = 1'b1;
    din = 9'b000_011_101;
    #12;
    chk("rst_tick", {28'd0, tick16}, 32'h1);
    chk("rst_busy", {31'd0, busy16}, 32'd0);
    chk("rst_done", {31'd0, done16}, 32'd0);
    chk("rst_bus", {16'd0, bus16}, 32'd0);
    for (int r = 0; r < 8; r++) chk($sformatf("rst_R%0d", r), {16'd0, r16[r]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("first_done", {31'd0, done16}, 32'd1);
    chk("first_tick", {28'd0, tick16}, 32'h2);
    chk("first_bus", {16'd0, bus16}, 32'hFFFD);
    run = 1'b0;
    @(negedge clk);
    m16[3] = 16'hFFFD;
    chk("first_R3", {16'd0, r16[3]}, 32'hFFFD);
    chk("first_idle", {28'd0, tick16}, 32'h1);

    for (int i = 0; i < 17; i++) apply(t16[i], 1'b0, i);

    // add R0,R1 with R0=8, R1=12: walk the three states
    @(negedge clk);
    run = 1'b1;
    din = 9'b001_000_001;
    @(negedge clk);
    run = 1'b0;
    chk("add_t1_tick", {28'd0, tick16}, 32'h2);
    chk("add_t1_bus", {16'd0, bus16}, 32'h8);
    chk("add_t1_done", {31'd0, done16}, 32'd0);
    chk("add_t1_busy", {31'd0, busy16}, 32'd1);
    @(negedge clk);
    chk("add_t2_tick", {28'd0, tick16}, 32'h4);
    chk("add_t2_bus", {16'd0, bus16}, 32'hC);
    chk("add_t2_done", {31'd0, done16}, 32'd0);
    @(negedge clk);
    chk("add_t3_tick", {28'd0, tick16}, 32'h8);
    chk("add_t3_bus", {16'd0, bus16}, 32'h14);
    chk("add_t3_done", {31'd0, done16}, 32'd1);
    @(negedge clk);
    chk("add_idle_tick", {28'd0, tick16}, 32'h1);
    chk("add_idle_bus", {16'd0, bus16}, 32'd0);
    chk("add_idle_busy", {31'd0, busy16}, 32'd0);
    chk("add_R0", {16'd0, r16[0]}, 32'h14);
    chk("add_R1", {16'd0, r16[1]}, 32'hC);

    // run held high: three back-to-back movi R7,2
    begin
      int ndone = 0;
      @(negedge clk);
      run = 1'b1;
      din = 9'b000_111_010;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk($sformatf("b2b_tick%0d", c), {28'd0, tick16}, {28'd0, exp_tick[c]});
        if (done16 === 1'b1) ndone++;
        if (c == 4) run = 1'b0;
      end
      chk("b2b_ndone", ndone, 3);
      chk("b2b_R7", {16'd0, r16[7]}, 32'h2);
    end

    // reset during T2 of add R0,R1 aborts with no write
    @(negedge clk);
    run = 1'b1;
    din = 9'b001_000_001;
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("abort_in_t2", {28'd0, tick16}, 32'h4);
    #2 rst = 1'b0;
    #1;
    chk("abort_tick", {28'd0, tick16}, 32'h1);
    chk("abort_busy", {31'd0, busy16}, 32'd0);
    chk("abort_done", {31'd0, done16}, 32'd0);
    chk("abort_bus", {16'd0, bus16}, 32'd0);
    for (int r = 0; r < 8; r++) chk($sformatf("abort_R%0d", r), {16'd0, r16[r]}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_done%0d", c), {31'd0, done16}, 32'd0);
      chk($sformatf("post_rst_tick%0d", c), {28'd0, tick16}, 32'h1);
    end

    // DATA_W=8 wrap and shift sequence (first entry also shows restart after reset)
    for (int i = 0; i < 10; i++) begin
      apply(t8[i], 1'b1, i);
      if (i == 0) chk("restart_w16_R2", {16'd0, r16[2]}, 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
